// File: rtl/mem_port_arbiter_if.sv
// Bundled request/response and memory-side signals of the shared memory
// port arbiter. The arbiter uses the slave modport; the requesters and the
// memory model together use the master modport.
interface mem_port_arbiter_if #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int CH         = 2
);
    // Requester side: flattened per-channel buses, channel i in slice i
    logic [CH-1:0]            req_valid;
    logic [CH-1:0]            req_we;
    logic [2*CH-1:0]          req_size;
    logic [CH*ADDR_WIDTH-1:0] req_addr;
    logic [CH*LEN-1:0]        req_wdata;
    logic [CH-1:0]            req_ready;
    logic [CH-1:0]            resp_valid;
    logic [LEN-1:0]           resp_rdata;
    logic                     resp_err;

    // Memory side
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [LEN-1:0]           write_data;
    logic [3:0]               mem_be;
    logic [1:0]               mem_vis_stage_state;
    logic [LEN-1:0]           mem_data;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, write_data, mem_be, mem_vis_stage_state
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, write_data, mem_be, mem_vis_stage_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: serialises byte/half/word loads and stores
// from CH requester channels onto one single-ported memory. One transaction
// at a time: IDLE (accept) -> ACCESS (memory cycles) -> RESP (one strobe).
// Misaligned requests skip ACCESS and answer with resp_err.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise fixed priority with the lowest channel winning.
module mem_port_arbiter #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int CH         = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active low
    input  logic              rdy_in,   // global enable, low freezes everything
    mem_port_arbiter_if.slave bus
);

    localparam int GW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t                state_reg, state_next;
    logic [GW-1:0]         g_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic [1:0]            lane_reg;
    logic [LEN-1:0]        wdata_reg;
    logic                  err_reg;
    logic [LEN-1:0]        rdata_reg;
    logic [2:0]            cnt_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;

    // Per-channel views of the flattened request buses
    logic [1:0]            ch_size  [CH];
    logic [ADDR_WIDTH-1:0] ch_addr  [CH];
    logic [LEN-1:0]        ch_wdata [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign ch_size[gi]  = bus.req_size[2*gi +: 2];
            assign ch_addr[gi]  = bus.req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
            assign ch_wdata[gi] = bus.req_wdata[LEN*gi +: LEN];
        end
    endgenerate

    logic                  any_valid;
    logic [GW-1:0]         grant;
    logic                  accept;
    logic                  misaligned;
    logic                  last_beat;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign any_valid = |bus.req_valid;
    assign sel_size  = ch_size[grant];
    assign sel_addr  = ch_addr[grant];
    // Half needs bit 0 clear, word (and the 11 encoding) needs both bits clear
    assign misaligned = ((sel_size == 2'b01) && sel_addr[0]) ||
                        (sel_size[1] && (sel_addr[1:0] != 2'b00));
    assign last_beat  = (cnt_reg == 3'(RD_LATENCY - 1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_reg;
    logic [GW:0]   rr_idx;
    logic          rr_found;

    // Round-robin pick: first valid channel at or after the pointer
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < CH; i++) begin
            rr_idx = (GW+1)'(ptr_reg) + (GW+1)'(i);
            if (rr_idx >= (GW+1)'(CH))
                rr_idx = rr_idx - (GW+1)'(CH);
            if (!rr_found && bus.req_valid[rr_idx[GW-1:0]]) begin
                rr_found = 1'b1;
                grant    = rr_idx[GW-1:0];
            end
        end
    end

    // Pointer moves past the channel just accepted, misaligned ones included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr_reg <= '0;
        else if (accept)
            ptr_reg <= (grant == GW'(CH - 1)) ? '0 : grant + GW'(1);
    end
`else
    // Fixed priority: scanning downwards leaves the lowest valid index
    always_comb begin
        grant = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (bus.req_valid[i])
                grant = GW'(i);
        end
    end
`endif

    // Next-state logic; accept only happens in IDLE with the port enabled
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (rdy_in && any_valid) begin
                    accept     = 1'b1;
                    state_next = misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (rdy_in && (we_reg || last_beat))
                    state_next = S_RESP;
            end
            S_RESP: begin
                if (rdy_in)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Lane extraction of the read word, little-endian, zero-extended
    logic [4:0]     lane_sh;
    logic [LEN-1:0] rd_shifted;
    logic [LEN-1:0] rd_lane;
    assign lane_sh    = {lane_reg, 3'b000};
    assign rd_shifted = bus.mem_data >> lane_sh;

    // Select byte/half/word out of the shifted read word
    always_comb begin
        rd_lane = rd_shifted;
        case (size_reg)
            2'b00:   rd_lane = LEN'(rd_shifted[7:0]);
            2'b01:   rd_lane = LEN'(rd_shifted[15:0]);
            default: rd_lane = rd_shifted;
        endcase
    end

    // State register, request latch and read-latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            g_reg        <= '0;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            lane_reg     <= 2'b00;
            wdata_reg    <= '0;
            err_reg      <= 1'b0;
            rdata_reg    <= '0;
            cnt_reg      <= '0;
            mem_addr_reg <= '0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            if (accept) begin
                g_reg     <= grant;
                we_reg    <= bus.req_we[grant];
                size_reg  <= sel_size;
                lane_reg  <= sel_addr[1:0];
                wdata_reg <= ch_wdata[grant];
                err_reg   <= misaligned;
                rdata_reg <= '0;     // stores and errors answer with zero data
                cnt_reg   <= '0;
                // Misaligned requests never touch memory, so mem_addr keeps its value
                if (!misaligned)
                    mem_addr_reg <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
            end
            if (state_reg == S_ACCESS && !we_reg) begin
                if (last_beat) begin
                    cnt_reg   <= '0;
                    rdata_reg <= rd_lane;
                end else begin
                    cnt_reg <= cnt_reg + 3'd1;
                end
            end
        end
    end

    // Store data masked to the access size before lane steering
    logic [LEN-1:0] wd_masked;
    logic [3:0]     be_base;

    // Size-dependent store mask and base byte-enable pattern
    always_comb begin
        wd_masked = wdata_reg;
        be_base   = 4'b1111;
        case (size_reg)
            2'b00: begin
                wd_masked = LEN'(wdata_reg[7:0]);
                be_base   = 4'b0001;
            end
            2'b01: begin
                wd_masked = LEN'(wdata_reg[15:0]);
                be_base   = 4'b0011;
            end
            default: ;
        endcase
    end

    // Memory-side strobes are live only during ACCESS
    always_comb begin
        bus.mem_vis_stage_state = 2'b00;
        bus.mem_be              = 4'b0000;
        bus.write_data          = '0;
        if (state_reg == S_ACCESS) begin
            if (we_reg) begin
                bus.mem_vis_stage_state = 2'b10;
                bus.mem_be              = be_base << lane_reg;
                bus.write_data          = wd_masked << lane_sh;
            end else begin
                bus.mem_vis_stage_state = 2'b01;
            end
        end
    end

    assign bus.mem_addr   = mem_addr_reg;
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = (state_reg == S_RESP) && rdy_in && err_reg;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_strobe
            assign bus.req_ready[gi]  = accept && (grant == GW'(gi));
            assign bus.resp_valid[gi] = (state_reg == S_RESP) && rdy_in &&
                                        (g_reg == GW'(gi));
        end
    endgenerate

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised shared-memory port arbiter that serialises load, store and fetch requests from `CH` requester channels onto the single-ported unified memory. It generalises the existing fixed IF/MEM address and data muxing with:
- a valid/ready request handshake;
- configurable read latency;
- byte/half/word lane steering;
- misalignment error responses;
- selectable arbitration.

It sits between the core pipeline stages and the external `mem_addr` / `mem_data` / `write_data` / `mem_vis_stage_state` bus.

## Interface
- `LEN`, 32: data word width; fixed multiple of 8, 4 byte lanes at 32.
- `ADDR_WIDTH`, 17: byte address width.
- `CH`, 2: number of requester channels, 2..4; channel 0 is the data (MEM stage) port by convention.
- `RD_LATENCY`, 1: memory read latency in cycles, 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `req_valid`  in  CH  per-channel request valid.
- `req_we`  in  CH  per-channel write enable.
- `req_size`  in  2*CH  per channel: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_addr`  in  CH*ADDR_WIDTH  per-channel byte address.
- `req_wdata`  in  CH*LEN  per-channel store data, right-aligned.
- `req_ready`  out  CH  per-channel accept strobe.
- `resp_valid`  out  CH  one-cycle response strobe to the granted channel.
- `resp_rdata`  out  LEN  load data, lane-extracted and zero-extended; shared by all channels.
- `resp_err`  out  1  misaligned-access flag, qualified by `resp_valid`.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address; low 2 bits always 0.
- `write_data`  out  LEN  store data shifted into byte lanes.
- `mem_be`  out  4  byte enables for stores.
- `mem_vis_stage_state`  out  2  00 idle, 01 read, 10 write.
- `mem_data`  in  LEN  memory read data.

## Operation
- **FSM states.** IDLE, ACCESS, RESP.
- **IDLE.**
  - If any `req_valid` bit is set, the arbiter picks grant `g`.
  - `req_ready[g]` is 1 combinationally; all other `req_ready` bits are 0.
  - On the clock edge the request is latched (addr, we, size, wdata, g).
- **Alignment check at latch.**
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]≠0.
  - A misaligned request goes to RESP with err=1 and no memory access.
  - Every other request goes to ACCESS.
- **ACCESS.**
  - Drives `mem_addr` = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Drives `mem_vis_stage_state` = 10 for a write, 01 for a read.
  - Writes: lane = addr[1:0]; `write_data` = wdata << 8*lane; `mem_be` = 0001/0011/1111 << lane. A write lasts 1 cycle, then goes to RESP.
  - Reads: a latency counter counts RD_LATENCY cycles. In the last cycle, `mem_data` is captured and lane-extracted (little-endian): bytes [8*lane+7:8*lane] and halves [8*lane+15:8*lane] are moved to bit 0 and zero-extended. Then goes to RESP.
- **RESP.** `resp_valid[g]` = 1 for exactly one cycle. `resp_rdata` is valid for reads; writes return 0. `resp_err` is as latched. Then returns to IDLE.
- **Arbitration.** Selected by `ROUND_ROBIN_EN` (see Configuration).
- **Outputs outside ACCESS.** `mem_vis_stage_state`=00, `mem_be`=0, `write_data`=0, and `mem_addr` holds its last value.
- **Request fields.** Requesters hold all request fields stable until accepted. Fields are sampled only at accept.

## Timing
- **Reset values.** All outputs are 0; state = IDLE; counter = 0; round-robin pointer = 0.
- **Reset mid-operation.** The transaction is aborted silently: no `resp_valid` is issued and no `mem_be` pulse follows after release.
- **Read latency.** Accept edge → ACCESS for RD_LATENCY cycles → RESP. `resp_valid` rises RD_LATENCY+1 cycles after the accept cycle.
- **Write latency.** `resp_valid` rises 2 cycles after accept.
- **Misaligned latency.** `resp_valid` rises 1 cycle after accept.
- **No back-to-back accept.** A new accept is possible only in the cycle after RESP.
- **`rdy_in` = 0.**
  - FSM, counter, pointer and latched request all hold.
  - `req_ready` and `resp_valid` are forced to 0.
  - Memory-side outputs hold their values.
  - A pending RESP is delivered in the first cycle `rdy_in` returns to 1.
- **Simultaneous valid requests.** Exactly one grant per IDLE cycle. Non-granted requesters wait with `req_ready`=0.
- **Counter wrap.** The counter resets to 0 on leaving ACCESS.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Priority search starts at pointer p. After each accept, p = (g+1) mod CH.
  - Misaligned accepts also advance p.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- **Reset mid-read.** Pull `rst` low mid-ACCESS of a read, hold 2 cycles, release with no requests → all outputs 0; `resp_valid` stays 0 for 10 cycles.
- **Word read, RD_LATENCY=2.** ch1 word read at 0x00104, `mem_data`=0xDEADBEEF → `mem_addr`=0x00104 with vis=01 for 2 cycles; `resp_valid`=2'b10 3 cycles after accept; `resp_rdata`=0xDEADBEEF.
- **Byte store.** ch0 byte write at 0x00013, wdata 0x000000AB → `mem_addr`=0x00010, `mem_be`=1000, `write_data`=0xAB000000, vis=10 for one cycle; `resp_valid`=2'b01 2 cycles after accept.
- **Half read.** ch0 half read at 0x00022, `mem_data`=0x12345678 → `resp_rdata`=0x00001234.
- **Misaligned half.** ch0 half at 0x00001 → vis stays 00; `resp_valid`=2'b01 with `resp_err`=1 one cycle after accept.
- **Contention and stall.**
  - Both channels valid continuously for 4 transactions → grants 0,1,0,1 with the macro defined; 0,0,0,0 without it.
  - `rdy_in` low for 3 cycles mid-ACCESS → `resp_valid` delayed by exactly 3 cycles; data unchanged.
